// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage: destination-select
// encodings, the link register index and register address width.
package writeback_regfile_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    DST_RD   = 2'b00,
    DST_RT   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } dst_sel_e;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  // Saturating increment for the 32-bit commit counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/writeback_regfile_core.sv
// Register storage: one write port, three combinational read ports.
// Register 0 is never written and always reads as zero.
module regfile_core
  import writeback_regfile_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NREGS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [NBITS-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] ra0,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [NBITS-1:0]      rd0,
  output logic [NBITS-1:0]      rd1,
  output logic [NBITS-1:0]      rd2
);

  logic [NREGS-1:0][NBITS-1:0] regs;

  function automatic logic [NBITS-1:0] rd_port(input logic [REG_ADDR_W-1:0] a);
    return (a == '0 || int'(a) >= NREGS) ? '0 : regs[a];
  endfunction

  // Reset clears every entry; otherwise commit the write, skipping r0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0 && int'(waddr) < NREGS) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational reads with r0 pinned to zero.
  always_comb begin
    rd0 = rd_port(ra0);
    rd1 = rd_port(ra1);
    rd2 = rd_port(ra2);
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: destination decode, result mux, register file and
// commit counter. Optional macro WB_BYPASS_EN makes the ID read ports
// write-through for the register being written this cycle; the debug
// port always shows the stored value.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NREGS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_flg_ALU_dst,
  input  logic                  i_neg_flg_mem_op,
  input  logic [NBITS-1:0]      i_ALU_rslt,
  input  logic [NBITS-1:0]      i_data,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [REG_ADDR_W-1:0] i_rt_addr,
  output logic [NBITS-1:0]      o_rs_data,
  output logic [NBITS-1:0]      o_rt_data,
  input  logic [REG_ADDR_W-1:0] i_dbg_addr,
  output logic [NBITS-1:0]      o_dbg_data,
  output logic                  o_wb_en,
  output logic [REG_ADDR_W-1:0] o_wb_addr,
  output logic [NBITS-1:0]      o_wb_data,
  output logic [31:0]           o_wb_count
);

  logic [NBITS-1:0] rs_raw, rt_raw;
  logic [31:0]      wb_count;

  // Destination decode and result select; DST_NONE still shows i_rd on
  // the address bus, but the enable stays low.
  always_comb begin
    o_wb_addr = i_rd;
    case (dst_sel_e'(i_flg_ALU_dst))
      DST_RD:   o_wb_addr = i_rd;
      DST_RT:   o_wb_addr = i_rt;
      DST_LINK: o_wb_addr = LINK_REG;
      default:  o_wb_addr = i_rd;
    endcase
    o_wb_data = i_neg_flg_mem_op ? i_ALU_rslt : i_data;
    o_wb_en   = (dst_sel_e'(i_flg_ALU_dst) != DST_NONE) && (o_wb_addr != '0) && !i_rst;
  end

  regfile_core #(.NBITS(NBITS), .NREGS(NREGS)) u_core (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .we    (o_wb_en),
    .waddr (o_wb_addr),
    .wdata (o_wb_data),
    .ra0   (i_rs_addr),
    .ra1   (i_rt_addr),
    .ra2   (i_dbg_addr),
    .rd0   (rs_raw),
    .rd1   (rt_raw),
    .rd2   (o_dbg_data)
  );

`ifdef WB_BYPASS_EN
  // Write-through: a read of the register being written sees the new data.
  always_comb begin
    o_rs_data = (o_wb_en && i_rs_addr == o_wb_addr) ? o_wb_data : rs_raw;
    o_rt_data = (o_wb_en && i_rt_addr == o_wb_addr) ? o_wb_data : rt_raw;
  end
`else
  // No bypass: readers see the stored value until the write commits.
  always_comb begin
    o_rs_data = rs_raw;
    o_rt_data = rt_raw;
  end
`endif

  // Saturating count of committed writes.
  always_ff @(posedge i_clk) begin
    if (i_rst)        wb_count <= '0;
    else if (o_wb_en) wb_count <= sat_inc32(wb_count);
  end

  assign o_wb_count = wb_count;

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter NBITS, default 32, datapath width.
REQ-002 Parameter NREGS, default 32, register count; address width fixed at 5.
REQ-003 i_clk  in  1  clock; all state updates on posedge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_flg_ALU_dst  in  2  destination select, driven by the MEM/WB stage register.
REQ-006 i_neg_flg_mem_op  in  1  0 = load result, 1 = ALU result.
REQ-007 i_ALU_rslt  in  NBITS  ALU result from MEM/WB.
REQ-008 i_data  in  NBITS  memory read data from MEM/WB.
REQ-009 i_rd, i_rt  in  5 each  candidate destination indices.
REQ-010 i_rs_addr, i_rt_addr  in  5 each  ID-stage read port addresses.
REQ-011 o_rs_data, o_rt_data  out  NBITS each  ID-stage read data, combinational.
REQ-012 i_dbg_addr  in  5, o_dbg_data  out  NBITS  debug-unit read port, combinational, never bypassed.
REQ-013 o_wb_en  out  1, o_wb_addr  out  5, o_wb_data  out  NBITS  current-cycle write, for the forwarding unit.
REQ-014 o_wb_count  out  32  registered count of committed writes.

Function
REQ-015 Destination decode: 00 -> i_rd; 01 -> i_rt; 10 -> register 31 (link); 11 -> no write.
REQ-016 Write data: i_data when i_neg_flg_mem_op = 0, else i_ALU_rslt.
REQ-017 o_wb_en = 1 iff destination select != 11, decoded address != 0, and i_rst = 0.
REQ-018 When o_wb_en = 1, the register at o_wb_addr takes o_wb_data at the posedge, with single-cycle latency.
REQ-019 Register 0 reads 0 on every port; writes to it are discarded and not counted.
REQ-020 o_wb_addr and o_wb_data show the decoded values even when o_wb_en = 0.
REQ-021 o_wb_count increments by 1 at each posedge with o_wb_en = 1.
REQ-022 o_wb_count saturates at 0xFFFFFFFF and does not wrap.
REQ-023 Reads of a register not being written return its stored value.
REQ-024 Two read ports at the same address return identical data.

Reset
REQ-025 While i_rst = 1 at a posedge, all NREGS registers clear to 0 and o_wb_count clears to 0.
REQ-026 A write presented in a reset cycle is dropped, and no partial update occurs.
REQ-027 o_wb_en is 0 throughout reset.
REQ-028 The first write is accepted on the first posedge with i_rst = 0.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: when a read port address equals o_wb_addr and o_wb_en = 1, the port returns o_wb_data in the same cycle (write-through).
REQ-030 Macro WB_BYPASS_EN undefined: read ports return the pre-write stored value, and the hazard unit covers the one-cycle gap.
REQ-031 The debug port is unaffected by WB_BYPASS_EN.

Structure
REQ-032 Shared pipeline package holds: DST_RD = 2'b00, DST_RT = 2'b01, DST_LINK = 2'b10, DST_NONE = 2'b11; LINK_REG = 31; REG_ADDR_W = 5.
REQ-033 The writeback mux/decode (REQ-015 to REQ-017) stays in the top module.
REQ-034 The storage array is one sub-module, regfile_core: one write port, three combinational read ports, register 0 hardwired to 0.

Verification
REQ-035 Reset, then read all 32 addresses -> all 0; o_wb_count = 0.
REQ-036 dst = 00, rd = 5, neg_mem = 1, ALU = 0x0000_00AA -> next cycle r5 = 0xAA; o_wb_count = 1.
REQ-037 dst = 01, rt = 7, neg_mem = 0, data = 0xDEAD_BEEF -> r7 = 0xDEADBEEF; dst = 10 with ALU = 0x40 -> r31 = 0x40.
REQ-038 dst = 00, rd = 0, ALU = 0x1234 -> r0 reads 0; o_wb_count unchanged; dst = 11 with rd = 3 -> r3 unchanged.
REQ-039 Write r9 = 0x55 while i_rs_addr = 9 -> o_rs_data = 0x55 in the same cycle with WB_BYPASS_EN defined; old value without it; o_dbg_data old value in both builds.
REQ-040 Force o_wb_count = 0xFFFFFFFE, then perform 3 writes -> 0xFFFFFFFF held; assert i_rst together with a write to r4 -> r4 = 0 and count = 0.
